// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the EXU writeback arbiter: the buffered result entry and the source indices.
package exu_wb_arb_pkg;

   localparam int unsigned WB_XLEN      = 32;
   localparam int unsigned WB_ADDR_W    = 5;
   localparam int unsigned WB_NUM_SRC   = 4;

   localparam int unsigned WB_SRC_ALU   = 0;
   localparam int unsigned WB_SRC_MUL   = 1;
   localparam int unsigned WB_SRC_DIV   = 2;
   localparam int unsigned WB_SRC_LSU   = 3;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd_addr;
      logic [WB_XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO. Full/empty are registered so producer ready never depends on this
// cycle's pop.
module wb_src_fifo
   import exu_wb_arb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  wb_entry_t wdata_i,
   input  logic      pop_i,
   output wb_entry_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   wb_entry_t       mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   cnt_q, cnt_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            do_push, do_pop;

   always_comb begin
      do_push  = push_i & ~full_q;
      do_pop   = pop_i & ~empty_q;
      wr_ptr_d = wr_ptr_q + PtrW'(do_push);
      rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
      cnt_d    = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
      full_d   = (cnt_d == (PtrW+1)'(Depth));
      empty_d  = (cnt_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; a slot is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/exu_wb_arb.sv
// EXU writeback arbiter: buffers ALU/MUL/DIV/LSU results and retires one per cycle to IDU1,
// with fixed priority DIV > MUL > LSU > ALU and age-based promotion of starving heads.
module exu_wb_arb
   import exu_wb_arb_pkg::*;
#(
   parameter int unsigned XLEN                = WB_XLEN,
   parameter int unsigned REG_FILE_ADDR_WIDTH = WB_ADDR_W,
   parameter int unsigned WB_FIFO_DEPTH       = 2,
   parameter int unsigned STARVE_LIMIT        = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [WB_NUM_SRC-1:0]                     src_valid,
   output logic [WB_NUM_SRC-1:0]                     src_ready,
   input  logic [WB_NUM_SRC*REG_FILE_ADDR_WIDTH-1:0] src_rd_addr,
   input  logic [WB_NUM_SRC*XLEN-1:0]                src_data,
   output logic [XLEN-1:0]                           exu_wb_data,
   output logic [REG_FILE_ADDR_WIDTH-1:0]            exu_wb_rd_addr,
   output logic                                      exu_wb_rd_wr_en,
   output logic                                      wb_pending,
   output logic                                      wb_overflow
);

   localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);

   wb_entry_t                     push_entry [WB_NUM_SRC];
   wb_entry_t                     head       [WB_NUM_SRC];
   logic      [WB_NUM_SRC-1:0]    full, empty, push;
   logic      [WB_NUM_SRC-1:0]    starved, grant;
   logic                          found;
   wb_entry_t                     win;
   logic      [AgeW-1:0]          age_q [WB_NUM_SRC];
   logic      [AgeW-1:0]          age_d [WB_NUM_SRC];

   logic [XLEN-1:0]                wb_data_q;
   logic [REG_FILE_ADDR_WIDTH-1:0] wb_addr_q;
   logic                           wb_wr_en_q;
   logic                           overflow_q;

   always_comb begin
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         push_entry[i].rd_addr = src_rd_addr[i*REG_FILE_ADDR_WIDTH +: REG_FILE_ADDR_WIDTH];
         push_entry[i].data    = src_data[i*XLEN +: XLEN];
      end
   end

   assign push = src_valid & ~full;

   for (genvar g = 0; g < WB_NUM_SRC; g++) begin : g_fifo
      wb_src_fifo #(
         .Depth (WB_FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk),
         .rst_i   (rst),
         .push_i  (push[g]),
         .wdata_i (push_entry[g]),
         .pop_i   (grant[g]),
         .rdata_o (head[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
   end

   // Starved heads pre-empt the fixed order; among them the lowest index wins.
   always_comb begin
      starved = '0;
      grant   = '0;
      found   = 1'b0;
      win     = '0;
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         starved[i] = ~empty[i] & (age_q[i] >= AgeW'(STARVE_LIMIT));
      end
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         if (starved[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      if (!found) begin
         if (!empty[WB_SRC_DIV]) begin
            grant[WB_SRC_DIV] = 1'b1;
         end else if (!empty[WB_SRC_MUL]) begin
            grant[WB_SRC_MUL] = 1'b1;
         end else if (!empty[WB_SRC_LSU]) begin
            grant[WB_SRC_LSU] = 1'b1;
         end else if (!empty[WB_SRC_ALU]) begin
            grant[WB_SRC_ALU] = 1'b1;
         end
      end
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         if (grant[i]) begin
            win = head[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         if (empty[i] || grant[i]) begin
            age_d[i] = '0;
         end else if (age_q[i] < AgeW'(STARVE_LIMIT)) begin
            age_d[i] = age_q[i] + AgeW'(1);
         end else begin
            age_d[i] = age_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
         if (rst) begin
            age_q[i] <= '0;
         end else begin
            age_q[i] <= age_d[i];
         end
      end
   end

   // Writes to x0 still consume their slot but never raise the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data_q  <= '0;
         wb_addr_q  <= '0;
         wb_wr_en_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wb_wr_en_q <= (|grant) & (win.rd_addr != '0);
         if (|grant) begin
            wb_data_q <= win.data;
            wb_addr_q <= win.rd_addr;
         end
         if (|(src_valid & full)) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign src_ready       = ~full;
   assign wb_pending      = ~&empty;
   assign exu_wb_data     = wb_data_q;
   assign exu_wb_rd_addr  = wb_addr_q;
   assign exu_wb_rd_wr_en = wb_wr_en_q;
   assign wb_overflow     = overflow_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_exu_wb_arb;
   import exu_wb_arb_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   localparam int NS    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src_valid;
   logic [3:0]  src_ready;
   logic [19:0] src_rd_addr;
   logic [127:0] src_data;
   logic [31:0] exu_wb_data;
   logic [4:0]  exu_wb_rd_addr;
   logic        exu_wb_rd_wr_en;
   logic        wb_pending;
   logic        wb_overflow;

   always #5 clk = ~clk;

   exu_wb_arb #(
      .XLEN                (32),
      .REG_FILE_ADDR_WIDTH (5),
      .WB_FIFO_DEPTH       (DEPTH),
      .STARVE_LIMIT        (LIMIT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .src_rd_addr     (src_rd_addr),
      .src_data        (src_data),
      .exu_wb_data     (exu_wb_data),
      .exu_wb_rd_addr  (exu_wb_rd_addr),
      .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
      .wb_pending      (wb_pending),
      .wb_overflow     (wb_overflow)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue of {rd,data} per source plus per-head wait counts.
   logic [36:0] mq [NS][$];
   int          mage [NS];
   logic [31:0] e_data;
   logic [4:0]  e_addr;
   logic        e_wr, e_pend, e_ovf;
   logic [3:0]  e_ready;
   bit          chk_en = 1'b0;

   task automatic model_step();
      int          sz [NS];
      int          prio [NS];
      int          w;
      logic [36:0] e;
      prio = '{2, 1, 3, 0};
      if (rst) begin
         for (int i = 0; i < NS; i++) begin
            mq[i].delete();
            mage[i] = 0;
         end
         e_data  = '0;
         e_addr  = '0;
         e_wr    = 1'b0;
         e_pend  = 1'b0;
         e_ovf   = 1'b0;
         e_ready = 4'hf;
         chk_en  = 1'b1;
         return;
      end
      for (int i = 0; i < NS; i++) sz[i] = mq[i].size();
      for (int i = 0; i < NS; i++) if (src_valid[i] && sz[i] >= DEPTH) e_ovf = 1'b1;
      w = -1;
      for (int i = 0; i < NS; i++) if (w < 0 && sz[i] > 0 && mage[i] >= LIMIT) w = i;
      for (int k = 0; k < NS; k++) if (w < 0 && sz[prio[k]] > 0) w = prio[k];
      e_wr = 1'b0;
      if (w >= 0) begin
         e      = mq[w].pop_front();
         e_addr = e[36:32];
         e_data = e[31:0];
         e_wr   = (e[36:32] != 5'd0);
      end
      for (int i = 0; i < NS; i++) begin
         if (sz[i] == 0 || i == w) mage[i] = 0;
         else mage[i] = (mage[i] < LIMIT) ? mage[i] + 1 : LIMIT;
         if (src_valid[i] && sz[i] < DEPTH)
            mq[i].push_back({src_rd_addr[i*5 +: 5], src_data[i*32 +: 32]});
      end
      e_pend = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (mq[i].size() > 0) e_pend = 1'b1;
         e_ready[i] = (mq[i].size() < DEPTH);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",   32'(src_ready),       32'(e_ready));
         check("pending", 32'(wb_pending),      32'(e_pend));
         check("ovf",     32'(wb_overflow),     32'(e_ovf));
         check("wr_en",   32'(exu_wb_rd_wr_en), 32'(e_wr));
         check("addr",    32'(exu_wb_rd_addr),  32'(e_addr));
         check("data",    exu_wb_data,          e_data);
      end
      model_step();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      src_valid[i]          = v;
      src_rd_addr[i*5 +: 5] = rd;
      src_data[i*32 +: 32]  = d;
   endtask

   logic [4:0] t2_exp [4];
   int         seen, lsu_sent, lsu_seen;

   initial begin
      src_valid   = '0;
      src_rd_addr = '0;
      src_data    = '0;
      rst         = 1'b1;
      t2_exp      = '{5'd3, 5'd2, 5'd4, 5'd1};
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(src_ready), 32'hf);
      check("rst_wr_en", 32'(exu_wb_rd_wr_en), 32'h0);
      check("rst_data", exu_wb_data, 32'h0);
      step();

      // Single ALU result: pending one cycle, strobe the cycle after.
      set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      src_valid = '0;
      @(negedge clk);
      check("t1_pend_n1", 32'(wb_pending), 32'h1);
      check("t1_wr_n1", 32'(exu_wb_rd_wr_en), 32'h0);
      step();
      @(negedge clk);
      check("t1_wr_n2", 32'(exu_wb_rd_wr_en), 32'h1);
      check("t1_addr_n2", 32'(exu_wb_rd_addr), 32'h5);
      check("t1_data_n2", exu_wb_data, 32'hDEADBEEF);
      check("t1_pend_n2", 32'(wb_pending), 32'h0);
      step();
      @(negedge clk);
      check("t1_wr_n3", 32'(exu_wb_rd_wr_en), 32'h0);
      check("t1_hold_n3", exu_wb_data, 32'hDEADBEEF);
      step();

      // All four at once retire in DIV, MUL, LSU, ALU order.
      set_src(0, 1'b1, 5'd1, 32'h11);
      set_src(1, 1'b1, 5'd2, 32'h22);
      set_src(2, 1'b1, 5'd3, 32'h33);
      set_src(3, 1'b1, 5'd4, 32'h44);
      step();
      src_valid = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clk);
         check("t2_wr", 32'(exu_wb_rd_wr_en), 32'h1);
         check("t2_order", 32'(exu_wb_rd_addr), 32'(t2_exp[k]));
      end
      repeat (2) step();

      // ALU head against a continuous DIV stream must be promoted.
      set_src(0, 1'b1, 5'd7, 32'h7);
      set_src(2, 1'b1, 5'd8, 32'h1000);
      step();
      src_valid[0] = 1'b0;
      seen = -1;
      for (int c = 0; c < 12; c++) begin
         set_src(2, src_ready[2], 5'd8, 32'h1000 + 32'(c));
         @(negedge clk);
         if (seen < 0 && exu_wb_rd_wr_en && exu_wb_rd_addr == 5'd7) seen = c;
         step();
      end
      src_valid = '0;
      check("t3_alu_starve_bound", 32'(seen >= 1 && seen <= 6), 32'h1);
      repeat (6) step();

      // LSU fills behind saturating MUL/DIV traffic and retires in order.
      lsu_sent = 0;
      lsu_seen = 0;
      for (int c = 0; c < 48; c++) begin
         set_src(1, src_ready[1], 5'd9, $urandom);
         set_src(2, src_ready[2], 5'd8, $urandom);
         if (lsu_sent < 3 && src_ready[3])
            set_src(3, 1'b1, 5'(20 + lsu_sent), 32'h300 + 32'(lsu_sent));
         else
            src_valid[3] = 1'b0;
         @(negedge clk);
         if (c == 2) check("t4_lsu_full", 32'(src_ready[3]), 32'h0);
         if (exu_wb_rd_wr_en && exu_wb_rd_addr >= 5'd20 && exu_wb_rd_addr <= 5'd22) begin
            check("t4_lsu_order", 32'(exu_wb_rd_addr), 32'(20 + lsu_seen));
            lsu_seen++;
         end
         if (src_valid[3]) lsu_sent++;
         step();
      end
      src_valid = '0;
      check("t4_lsu_retired", 32'(lsu_seen), 32'h3);
      check("t4_no_ovf", 32'(wb_overflow), 32'h0);
      repeat (8) step();

      // x0 consumes a slot silently; the following rd6 lands one cycle later.
      set_src(0, 1'b1, 5'd0, 32'h55);
      step();
      set_src(0, 1'b1, 5'd6, 32'h66);
      step();
      src_valid = '0;
      @(negedge clk);
      check("t5_x0_wr", 32'(exu_wb_rd_wr_en), 32'h0);
      step();
      @(negedge clk);
      check("t5_rd6_wr", 32'(exu_wb_rd_wr_en), 32'h1);
      check("t5_rd6_addr", 32'(exu_wb_rd_addr), 32'h6);
      check("t5_rd6_data", exu_wb_data, 32'h66);
      step();

      // Reset with full FIFOs discards everything.
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NS; i++) set_src(i, src_ready[i], 5'(10 + i), 32'hA0 + 32'(i));
         step();
      end
      src_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t6_wr", 32'(exu_wb_rd_wr_en), 32'h0);
      check("t6_pend", 32'(wb_pending), 32'h0);
      check("t6_ready", 32'(src_ready), 32'hf);
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         check("t6_no_stale", 32'(exu_wb_rd_wr_en), 32'h0);
      end
      step();

      // Random traffic, mostly respecting ready, with rare resets.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NS; i++) begin
            logic v;
            v = ($urandom_range(0, 2) != 0);
            if (!src_ready[i] && $urandom_range(0, 63) != 0) v = 1'b0;
            set_src(i, v, 5'($urandom_range(0, 31)), $urandom);
         end
         step();
      end
      rst = 1'b0;
      src_valid = '0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Ignoring ready on every source must trip the sticky overflow flag.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(i + 1), 32'(c));
         step();
      end
      src_valid = '0;
      @(negedge clk);
      check("ovf_sticky", 32'(wb_overflow), 32'h1);
      repeat (12) step();
      @(negedge clk);
      check("ovf_still_set", 32'(wb_overflow), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
